// File: rtl/serial_nibble_adder_pkg.sv
// Shared constants and FSM state encoding for serial_nibble_adder.
// The state encoding is fixed so waveform decoders can read it directly.
package serial_nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_nibble_adder_four_bit_adder.sv
// Combinational 4-bit adder with carry in/out, reused one nibble at a time
// by serial_nibble_adder.
module four_bit_adder
    import serial_nibble_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-cycle adder: walks the operands one nibble per cycle through a single
// four_bit_adder, chaining the carry through a flop, with a start/busy/done handshake.
module serial_nibble_adder
    import serial_nibble_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        cout
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       aOp_q, aOp_d;
    logic [W-1:0]       bOp_q, bOp_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;

    logic [NIBBLE_W-1:0] aNib, bNib, addSum;
    logic                addCout;

    // Explicit compare-and-select keeps the operand mux in range for any NIBBLES.
    always_comb begin
        aNib = '0;
        bNib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                aNib = aOp_q[i*NIBBLE_W +: NIBBLE_W];
                bNib = bOp_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    four_bit_adder u_adder (
        .a    (aNib),
        .b    (bNib),
        .cin  (carry_q),
        .sum  (addSum),
        .cout (addCout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        aOp_d   = aOp_q;
        bOp_d   = bOp_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    aOp_d   = a;
                    bOp_d   = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*NIBBLE_W +: NIBBLE_W] = addSum;
                    end
                end
                carry_d = addCout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = addCout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            aOp_q   <= '0;
            bOp_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            aOp_q   <= aOp_d;
            bOp_q   <= bOp_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
